// File: rtl/r22sdf_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// r22sdf_frame_ctrl_if
// Streaming bus of the R2^2SDF frame controller.
//   s_valid/s_ready/s_data : input sample stream, s_data = {re, im}
//   m_valid/m_ready/m_data : output result stream, m_data = {re, im}
//   m_first/m_last/m_bin   : frame markers and bin index of the held word
//
// Handshake: a word moves when valid & ready are both high at a rising clk
// edge. A source must not change data or drop valid while valid is high and
// ready is low.
//
// Modports: slave = the controller, master = the stream source/sink side.
// ---------------------------------------------------------------------------
interface r22sdf_frame_ctrl_if #(
  parameter int STG = 3,
  parameter int DW  = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [2*DW-1:0]   s_data;
  logic              m_valid;
  logic              m_ready;
  logic [2*DW-1:0]   m_data;
  logic              m_first;
  logic              m_last;
  logic [2*STG-1:0]  m_bin;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_first, m_last, m_bin
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_first, m_last, m_bin
  );
endinterface

// File: rtl/r22sdf_frame_ctrl.sv
// ---------------------------------------------------------------------------
// r22sdf_frame_ctrl
// Frame controller wrapped around a radix-2^2 single-path delay-feedback FFT
// core. Every pipeline advance (adv) moves the core by one sample; the core
// only advances when the output register can take a word, so back-pressure
// freezes the whole pipeline. A flush request waits for the current frame to
// finish, then pushes zero pads through the core until all real results have
// been emitted.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset (core shares rst)
//   bus (slave)       : input/output streams, see r22sdf_frame_ctrl_if
//   flush_req         : request to drain the pipeline at the next frame end
//   busy              : flush pending or in progress
//   cfg_scale/invexp  : passed straight to the core (core latches at sync)
//   core_en           : core advance strobe
//   core_in           : core sample (zero while padding)
//   core_sync         : marks the last sample of a frame
//   core_scale/invexp : core configuration
//   core_out          : core result, LAT advances behind core_in
//   dbg_state_o       : flush FSM state for observation
//
// Build option: define R22SDF_BITREV_IDX_EN to report m_bin in bit-reversed
// order; otherwise m_bin is the natural output count.
// ---------------------------------------------------------------------------
module r22sdf_frame_ctrl #(
  parameter int STG = 3,
  parameter int DW  = 16,
  parameter int LAT = 4**STG + STG - 2
) (
  input  logic                clk,
  input  logic                rst,
  r22sdf_frame_ctrl_if.slave  bus,
  input  logic                flush_req,
  output logic                busy,
  input  logic                cfg_scale,
  input  logic                cfg_invexp,
  output logic                core_en,
  output logic [2*DW-1:0]     core_in,
  output logic                core_sync,
  output logic                core_scale,
  output logic                core_invexp,
  input  logic [2*DW-1:0]     core_out,
  output logic [1:0]          dbg_state_o
);

  localparam int N    = 4**STG;
  localparam int CW   = 2*STG;
  // Whole frames of padding so the frame counter ends the flush back at 0.
  localparam int PADS = ((LAT + N - 1) / N) * N;
  localparam int PW   = $clog2(PADS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     ocnt_q, ocnt_d;
  logic [PW-1:0]     pad_q, pad_d;
  logic [LAT-1:0]    tag_q, tag_d;
  logic              m_valid_q, m_valid_d;
  logic [2*DW-1:0]   m_data_q, m_data_d;
  logic              m_first_q, m_first_d;
  logic              m_last_q, m_last_d;
  logic [CW-1:0]     m_bin_q, m_bin_d;

  logic              flush_active;
  logic              out_free;
  logic              adv;
  logic              load;
  logic [CW-1:0]     bin_idx;

`ifdef R22SDF_BITREV_IDX_EN
  function automatic logic [CW-1:0] bit_rev(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    for (int i = 0; i < CW; i++) r[i] = v[CW-1-i];
    return r;
  endfunction
  assign bin_idx = bit_rev(ocnt_q);
`else
  assign bin_idx = ocnt_q;
`endif

  assign flush_active = (state_q == ST_FLUSH);
  assign out_free     = ~m_valid_q | bus.m_ready;
  // Pads advance unconditionally in FLUSH; otherwise only a real sample does.
  assign adv          = ~rst & out_free & (flush_active | bus.s_valid);
  // Tag marks which core result belongs to a real sample.
  assign load         = adv & tag_q[LAT-1];

  assign bus.s_ready  = ~rst & out_free & ~flush_active;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_first  = m_first_q;
  assign bus.m_last   = m_last_q;
  assign bus.m_bin    = m_bin_q;

  assign core_en      = adv;
  assign core_in      = flush_active ? '0 : bus.s_data;
  assign core_sync    = adv & (cnt_q == CW'(N - 1));
  assign core_scale   = cfg_scale;
  assign core_invexp  = cfg_invexp;
  assign busy         = (state_q != ST_IDLE);
  assign dbg_state_o  = state_q;

  always_comb begin
    cnt_d     = cnt_q;
    ocnt_d    = ocnt_q;
    pad_d     = pad_q;
    state_d   = state_q;
    tag_d     = tag_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_first_d = m_first_q;
    m_last_d  = m_last_q;
    m_bin_d   = m_bin_q;

    if (adv) begin
      cnt_d = cnt_q + 1'b1;
      tag_d = {tag_q[LAT-2:0], ~flush_active};
    end

    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = core_out;
      m_first_d = (ocnt_q == '0);
      m_last_d  = (ocnt_q == CW'(N - 1));
      m_bin_d   = bin_idx;
      ocnt_d    = ocnt_q + 1'b1;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (flush_req) state_d = ST_PEND;
      end
      ST_PEND: begin
        // Leave once the frame counter lands on 0: either already there with
        // no sample this cycle, or this advance closes the frame.
        if (cnt_d == '0) begin
          state_d = ST_FLUSH;
          pad_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (adv) begin
          if (pad_q == PW'(PADS - 1)) begin
            state_d = ST_IDLE;
            pad_d   = '0;
          end else begin
            pad_d = pad_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ocnt_q    <= '0;
      pad_q     <= '0;
      tag_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_bin_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ocnt_q    <= ocnt_d;
      pad_q     <= pad_d;
      tag_q     <= tag_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_first_q <= m_first_d;
      m_last_q  <= m_last_d;
      m_bin_q   <= m_bin_d;
    end
  end

endmodule
